// File: rtl/vga_timing_generator.sv
// rtl/vga_timing_generator.sv - parametrised raster timing generator with registered sync/active/strobe outputs
//
// Ports:
//   i_Clk         system clock, rising edge
//   i_Rst_n       synchronous active-low reset
//   i_En          pixel tick; position advances only when high
//   o_HPos        current pixel column, 0..H_TOTAL-1
//   o_VPos        current line, 0..V_TOTAL-1
//   o_HSync       horizontal sync at HSYNC_POL
//   o_VSync       vertical sync at VSYNC_POL
//   o_Active      visible-region flag
//   o_LineStart   high while o_HPos == 0
//   o_FrameStart  high while o_HPos == 0 and o_VPos == 0
//   o_FrameCount  completed-frame counter (only with VGA_FRAME_COUNT_EN)
//
// Optional feature macro: VGA_FRAME_COUNT_EN

module vga_timing_generator #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int POS_W     = 10,
    parameter int FRAME_W   = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_En,
    output logic [POS_W-1:0] o_HPos,
    output logic [POS_W-1:0] o_VPos,
    output logic             o_HSync,
    output logic             o_VSync,
    output logic             o_Active,
    output logic             o_LineStart,
`ifdef VGA_FRAME_COUNT_EN
    output logic             o_FrameStart,
    output logic [FRAME_W-1:0] o_FrameCount
`else
    output logic             o_FrameStart
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Elaboration-time parameter sanity checks.
    if (H_TOTAL > (1 << POS_W)) begin : g_chk_htotal
        $error("H_TOTAL does not fit in POS_W bits");
    end
    if (V_TOTAL > (1 << POS_W)) begin : g_chk_vtotal
        $error("V_TOTAL does not fit in POS_W bits");
    end
    if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1) begin : g_chk_hwidths
        $error("horizontal porch and sync widths must be at least 1");
    end
    if (V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_chk_vwidths
        $error("vertical porch and sync widths must be at least 1");
    end
    if (FRAME_W < 1) begin : g_chk_framew
        $error("FRAME_W must be at least 1");
    end

    localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] H_ACT_C  = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] V_ACT_C  = POS_W'(V_ACTIVE);
    localparam logic [POS_W-1:0] HS_START = POS_W'(H_ACTIVE + H_FRONT);
    localparam logic [POS_W-1:0] HS_END   = POS_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [POS_W-1:0] VS_START = POS_W'(V_ACTIVE + V_FRONT);
    localparam logic [POS_W-1:0] VS_END   = POS_W'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic             HS_ON    = 1'(HSYNC_POL);
    localparam logic             VS_ON    = 1'(VSYNC_POL);

    logic [POS_W-1:0] h_nxt;
    logic [POS_W-1:0] v_nxt;

    // Next-state position; decodes below are taken from this so every
    // registered output describes the position it is registered with.
    always_comb begin
        h_nxt = o_HPos + POS_W'(1);
        v_nxt = o_VPos;
        if (o_HPos == H_LAST) begin
            h_nxt = '0;
            if (o_VPos == V_LAST) begin
                v_nxt = '0;
            end else begin
                v_nxt = o_VPos + POS_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            o_HPos       <= H_LAST;
            o_VPos       <= V_LAST;
            o_HSync      <= ~HS_ON;
            o_VSync      <= ~VS_ON;
            o_Active     <= 1'b0;
            o_LineStart  <= 1'b0;
            o_FrameStart <= 1'b0;
        end else if (i_En) begin
            o_HPos       <= h_nxt;
            o_VPos       <= v_nxt;
            o_HSync      <= (h_nxt >= HS_START && h_nxt < HS_END) ? HS_ON : ~HS_ON;
            o_VSync      <= (v_nxt >= VS_START && v_nxt < VS_END) ? VS_ON : ~VS_ON;
            o_Active     <= (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
            o_LineStart  <= (h_nxt == '0);
            o_FrameStart <= (h_nxt == '0) && (v_nxt == '0);
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    // Reset to all ones so the first frame after reset reads zero.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            o_FrameCount <= '1;
        end else if (i_En && h_nxt == '0 && v_nxt == '0) begin
            o_FrameCount <= o_FrameCount + FRAME_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// tb/tb_vga_timing_generator.sv - self-checking bench for vga_timing_generator

module tb_vga_timing_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, rst_b, en_b;
    logic [9:0] a_h, a_v;
    logic       a_hs, a_vs, a_act, a_ls, a_fs;
    logic [3:0] b_h, b_v;
    logic       b_hs, b_vs, b_act, b_ls, b_fs;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] fc_a;
    logic [1:0] fc_b;
`endif

    vga_timing_generator u_a (
        .i_Clk(clk), .i_Rst_n(rst_a), .i_En(en_a),
        .o_HPos(a_h), .o_VPos(a_v), .o_HSync(a_hs), .o_VSync(a_vs),
        .o_Active(a_act), .o_LineStart(a_ls),
`ifdef VGA_FRAME_COUNT_EN
        .o_FrameStart(a_fs), .o_FrameCount(fc_a)
`else
        .o_FrameStart(a_fs)
`endif
    );

    vga_timing_generator #(
        .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1), .VSYNC_POL(1), .POS_W(4), .FRAME_W(2)
    ) u_b (
        .i_Clk(clk), .i_Rst_n(rst_b), .i_En(en_b),
        .o_HPos(b_h), .o_VPos(b_v), .o_HSync(b_hs), .o_VSync(b_vs),
        .o_Active(b_act), .o_LineStart(b_ls),
`ifdef VGA_FRAME_COUNT_EN
        .o_FrameStart(b_fs), .o_FrameCount(fc_b)
`else
        .o_FrameStart(b_fs)
`endif
    );

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs, vs, act, ls, fs;
    } exp_t;

    typedef struct {
        logic rst, en;
        int   h, v;
        logic hs, vs, act, ls, fs;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int ah, av, bh, bv, bfc;
    exp_t qa[$];
    exp_t qb[$];
    int   qfc[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
        end
    endtask

    function automatic exp_t decode(input int h, input int v,
                                    input int ha, input int hf, input int hw,
                                    input int va, input int vf, input int vw,
                                    input int hp, input int vp);
        exp_t e;
        e.h   = 10'(h);
        e.v   = 10'(v);
        e.hs  = (h >= ha + hf && h < ha + hf + hw) ? 1'(hp) : ~1'(hp);
        e.vs  = (v >= va + vf && v < va + vf + vw) ? 1'(vp) : ~1'(vp);
        e.act = (h < ha) && (v < va);
        e.ls  = (h == 0);
        e.fs  = (h == 0) && (v == 0);
        return e;
    endfunction

    task automatic adv(inout int h, inout int v, input int ht, input int vt);
        if (h < ht - 1) begin
            h++;
        end else begin
            h = 0;
            v = (v == vt - 1) ? 0 : v + 1;
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        int   f;
        e = qa.pop_front();
        chk("a_hpos", 32'(a_h), 32'(e.h));
        chk("a_vpos", 32'(a_v), 32'(e.v));
        chk("a_hsync", 32'(a_hs), 32'(e.hs));
        chk("a_vsync", 32'(a_vs), 32'(e.vs));
        chk("a_active", 32'(a_act), 32'(e.act));
        chk("a_linestart", 32'(a_ls), 32'(e.ls));
        chk("a_framestart", 32'(a_fs), 32'(e.fs));
        e = qb.pop_front();
        chk("b_hpos", 32'(b_h), 32'(e.h));
        chk("b_vpos", 32'(b_v), 32'(e.v));
        chk("b_hsync", 32'(b_hs), 32'(e.hs));
        chk("b_vsync", 32'(b_vs), 32'(e.vs));
        chk("b_active", 32'(b_act), 32'(e.act));
        chk("b_linestart", 32'(b_ls), 32'(e.ls));
        chk("b_framestart", 32'(b_fs), 32'(e.fs));
        f = qfc.pop_front();
`ifdef VGA_FRAME_COUNT_EN
        chk("b_framecount", 32'(fc_b), 32'(f));
`endif
    endtask

    // Drive one cycle, advance the reference model, queue expectations,
    // then compare once the DUT has registered the edge.
    task automatic cyc(input logic ra, input logic ea, input logic rb, input logic eb);
        rst_a = ra; en_a = ea; rst_b = rb; en_b = eb;
        if (!ra) begin
            ah = 799; av = 524;
        end else if (ea) begin
            adv(ah, av, 800, 525);
        end
        if (!rb) begin
            bh = 11; bv = 6; bfc = 3;
        end else if (eb) begin
            adv(bh, bv, 12, 7);
            if (bh == 0 && bv == 0) bfc = (bfc + 1) % 4;
        end
        qa.push_back(decode(ah, av, 640, 16, 96, 480, 10, 2, 0, 0));
        qb.push_back(decode(bh, bv, 8, 1, 2, 4, 1, 1, 1, 1));
        qfc.push_back(bfc);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        vec_t tbl[6];
        int   hs_cnt, hs_first, hs_last, ls_cnt, guard;
        int   fs_cnt, vs_cnt, last_fs, fc_idx;
        int   fc_exp[5];

        tbl[0] = '{1'b0, 1'b1, 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b1,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1,   2,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        fc_exp = '{0, 1, 2, 3, 0};

        rst_a = 1'b0; en_a = 1'b0; rst_b = 1'b0; en_b = 1'b0;

        for (int i = 0; i < 6; i++) begin
            cyc(tbl[i].rst, tbl[i].en, 1'b0, 1'b0);
            chk("tbl_hpos", 32'(a_h), 32'(tbl[i].h));
            chk("tbl_vpos", 32'(a_v), 32'(tbl[i].v));
            chk("tbl_hsync", 32'(a_hs), 32'(tbl[i].hs));
            chk("tbl_vsync", 32'(a_vs), 32'(tbl[i].vs));
            chk("tbl_active", 32'(a_act), 32'(tbl[i].act));
            chk("tbl_linestart", 32'(a_ls), 32'(tbl[i].ls));
            chk("tbl_framestart", 32'(a_fs), 32'(tbl[i].fs));
        end

        // Rest of the first line: sync window, active fall, line wrap.
        hs_cnt = 0; hs_first = -1; hs_last = -1; ls_cnt = 0; guard = 0;
        while (!(ah == 0 && av == 1) && guard < 1000) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            guard++;
            if (a_hs == 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(a_h);
                hs_last = int'(a_h);
            end
            if (a_ls) ls_cnt++;
            if (a_h == 10'd640) chk("active_fall", 32'(a_act), 32'd0);
        end
        chk("line_guard", 32'(guard < 1000), 32'd1);
        chk("hsync_width", 32'(hs_cnt), 32'd96);
        chk("hsync_first", 32'(hs_first), 32'd656);
        chk("hsync_last", 32'(hs_last), 32'd751);
        chk("linestart_cnt", 32'(ls_cnt), 32'd1);
        chk("line_wrap_vpos", 32'(a_v), 32'd1);

        // Gated strobe holds until the next enabled edge.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            chk("ls_gated_hold", 32'(a_ls), 32'd1);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("ls_gated_end", 32'(a_ls), 32'd0);

        for (int i = 0; i < 16; i++) cyc(1'b1, (i % 4) == 3, 1'b0, 1'b0);
        chk("one_of_four_hpos", 32'(a_h), 32'd5);

        // Freeze in the middle of horizontal sync.
        guard = 0;
        while (ah != 700 && guard < 1000) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("freeze_hpos", 32'(a_h), 32'd700);
        chk("freeze_hsync", 32'(a_hs), 32'd0);

        // Small raster, positive polarity: five frames.
        fs_cnt = 0; vs_cnt = 0; last_fs = -1; fc_idx = 0;
        for (int i = 0; i < 420; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b1);
            if (i < 84 && b_vs) vs_cnt++;
            if (b_fs) begin
                if (last_fs >= 0) chk("frame_period", 32'(i - last_fs), 32'd84);
                last_fs = i;
                fs_cnt++;
`ifdef VGA_FRAME_COUNT_EN
                if (fc_idx < 5) chk("fc_sequence", 32'(fc_b), 32'(fc_exp[fc_idx]));
`endif
                fc_idx++;
            end
        end
        chk("frame_count_pulses", 32'(fs_cnt), 32'd5);
        chk("vsync_clocks", 32'(vs_cnt), 32'd12);

        guard = 0;
        while (!(bh == 5 && bv == 3) && guard < 200) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b1);
            guard++;
        end
        chk("b_pre_reset_hpos", 32'(b_h), 32'd5);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("b_reset_hpos", 32'(b_h), 32'd11);
        chk("b_reset_vpos", 32'(b_v), 32'd6);
`ifdef VGA_FRAME_COUNT_EN
        chk("b_reset_fc", 32'(fc_b), 32'd3);
`endif
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("b_restart_fs", 32'(b_fs), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

- Parametrised raster timing generator.
- Owns the horizontal and vertical position counters and derives HSync, VSync, active-video and line/frame strobes from them.
- Every output is registered and mutually aligned.
- Replaces the fixed 640x480 decode path. It feeds pixel generators and the sync output pins directly.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of o_HSync (0 = active-low)
- VSYNC_POL, 0, asserted level of o_VSync
- POS_W, 10, position counter width
- FRAME_W, 8, frame counter width (only with VGA_FRAME_COUNT_EN)

Ports:
- i_Clk  in  1  system clock; all logic on rising edge
- i_Rst_n  in  1  synchronous active-low reset
- i_En  in  1  pixel tick; counters advance only on cycles with i_En=1
- o_HPos  out  POS_W  current pixel column, 0..H_TOTAL-1
- o_VPos  out  POS_W  current line, 0..V_TOTAL-1
- o_HSync  out  1  horizontal sync at configured polarity
- o_VSync  out  1  vertical sync at configured polarity
- o_Active  out  1  high when o_HPos < H_ACTIVE and o_VPos < V_ACTIVE
- o_LineStart  out  1  high while o_HPos == 0
- o_FrameStart  out  1  high while o_HPos == 0 and o_VPos == 0
- o_FrameCount  out  FRAME_W  completed-frame counter (only with VGA_FRAME_COUNT_EN)

## Operation
- Derived totals:
  - H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK (default 800).
  - V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK (default 525).
- Parameter constraints (elaboration error on violation):
  - H_TOTAL and V_TOTAL each ≤ 2^POS_W.
  - Every porch and sync width ≥ 1.
- On a cycle with i_En=1:
  - If hpos < H_TOTAL-1: hpos increments.
  - Otherwise hpos wraps to 0, and vpos increments, or wraps to 0 when vpos == V_TOTAL-1.
- On a cycle with i_En=0, all registers hold.
- HSync is asserted for H_ACTIVE+H_FRONT ≤ hpos < H_ACTIVE+H_FRONT+H_SYNC (default columns 656..751).
- VSync is asserted for V_ACTIVE+V_FRONT ≤ vpos < V_ACTIVE+V_FRONT+V_SYNC (default lines 490..491). VSync is whole-line: it changes together with the vpos change at hpos wrap.
- Deasserted sync level is the inverse of the corresponding POL parameter.
- All decoded outputs are computed from the next-state position and registered, so each output always describes the o_HPos/o_VPos presented in the same cycle.
- No combinational path runs from i_En to any output.

## Timing
- Reset (i_Rst_n=0 on a rising edge) loads:
  - o_HPos = H_TOTAL-1 (799), o_VPos = V_TOTAL-1 (524), i.e. the last blanked pixel of a frame.
  - o_Active = 0, o_HSync = !HSYNC_POL, o_VSync = !VSYNC_POL.
  - o_LineStart = 0, o_FrameStart = 0.
- Reset dominates i_En.
- Reset mid-frame discards the current position immediately; no partial-frame flush.
- First i_En=1 cycle after reset moves to (0,0): o_FrameStart = o_LineStart = o_Active = 1 in the following cycle.
- Latency: one clock from an i_En=1 edge to the updated position and decodes.
- With i_En held high, strobe pulses are exactly one clock wide.
- With i_En gated, strobe pulses last one pixel period (from the enabled edge to the next enabled edge).
- Simultaneous hpos and vpos wrap at (H_TOTAL-1, V_TOTAL-1) is the frame boundary. It is the only event that asserts o_FrameStart.

## Configuration
- Macro: VGA_FRAME_COUNT_EN.
- Defined:
  - Port o_FrameCount exists.
  - Reset value is all ones.
  - It increments, modulo 2^FRAME_W, on each transition into (0,0), so the first frame after reset reads 0.
  - It is aligned with o_FrameStart.
- Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then hold i_Rst_n=0 with i_En=1 → o_HPos=799, o_VPos=524, o_Active=0, o_HSync=o_VSync=1, strobes 0.
- Release reset, i_En=1 continuous → next cycle (0,0) with FrameStart=LineStart=Active=1. At hpos 639→640, Active falls.
- Full line with defaults → o_HSync low exactly for hpos 656..751 (96 clocks). At 799→0, vpos increments and LineStart pulses for 1 clock.
- Full frame → o_VSync low exactly for vpos 490..491 (1600 clocks, starting at hpos 0). FrameStart recurs every 420000 clocks.
- i_En toggling 1-of-4 → positions advance once per 4 clocks and strobes stay high 4 clocks. i_En=0 for 10 clocks mid-sync → all outputs frozen.
- HSYNC_POL=1, VSYNC_POL=1, H_ACTIVE=8 H_FRONT=1 H_SYNC=2 H_BACK=1, V 4/1/1/1 → HSync high at hpos 9..10, VSync high at vpos 5. With VGA_FRAME_COUNT_EN and FRAME_W=2: counter reads 0,1,2,3,0 across 5 frames. Reset asserted at (5,3) → back to (11,6) next cycle and counter back to all ones.
